// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package mem_arb_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    // Which requester currently owns the memory port.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    // Default number of ACCESS cycles allowed without mem_ready.
    localparam int unsigned TIMEOUT_DEFAULT = 15;

    // Fair two-way pick: a lone request wins, a contest goes to the side
    // that was not granted last time.
    function automatic owner_e pick_owner(input logic   if_req,
                                          input logic   d_req,
                                          input owner_e last_grant);
        owner_e pick_s;
        if (if_req && d_req) begin
            pick_s = (last_grant == OWN_D) ? OWN_IF : OWN_D;
        end else if (d_req) begin
            pick_s = OWN_D;
        end else begin
            pick_s = OWN_IF;
        end
        return pick_s;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts ACCESS cycles and flags the cycle in which the limit is reached.
module mem_wait_timer
    import mem_arb_pkg::*;
#(
    parameter int unsigned LIMIT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // Counter value at which the current enabled cycle is the LIMIT-th one.
    localparam logic [3:0] LAST_COUNT = 4'(LIMIT - 1);

    logic [3:0] count_r;

    // Wait counter: clear has priority over counting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= 4'd0;
        end else if (clear) begin
            count_r <= 4'd0;
        end else if (enable) begin
            count_r <= count_r + 4'd1;
        end else begin
            count_r <= count_r;
        end
    end

    // Expiry is reported during the cycle that completes the LIMIT-th count.
    always_comb begin
        expired = enable && (count_r == LAST_COUNT);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one shared memory port.
// One access at a time: IDLE -> ACCESS -> RESP, with a wait timeout.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err,
    output logic              busy
);

    arb_state_e        state_r;
    arb_state_e        state_next_s;
    owner_e            owner_r;
    owner_e            last_grant_r;
    owner_e            grant_s;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;

    logic              tmr_clear_s;
    logic              tmr_enable_s;
    logic              tmr_expired_s;
    logic              timeout_s;

    logic              mem_en_n_s;
    logic              mem_we_n_s;
    logic              if_ack_n_s;
    logic              d_ack_n_s;
    logic              err_n_s;
    logic              busy_n_s;

    logic              mem_en_r;
    logic              mem_we_r;
    logic              if_ack_r;
    logic              d_ack_r;
    logic              err_r;
    logic              busy_r;
    logic [DATA_W-1:0] if_rdata_r;
    logic [DATA_W-1:0] d_rdata_r;

    // Timer runs only in ACCESS and restarts whenever ACCESS is left.
    always_comb begin
        grant_s      = pick_owner(if_req, d_req, last_grant_r);
        tmr_enable_s = (state_r == ST_ACCESS);
        tmr_clear_s  = (state_next_s != ST_ACCESS);
        timeout_s    = (state_r == ST_ACCESS) && !mem_ready && tmr_expired_s;
    end

    mem_wait_timer #(
        .LIMIT   (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmr_clear_s),
        .enable  (tmr_enable_s),
        .expired (tmr_expired_s)
    );

    // State register plus the access context latched at grant time.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            owner_r      <= OWN_IF;
            last_grant_r <= OWN_D;
            we_r         <= 1'b0;
            addr_r       <= {ADDR_W{1'b0}};
            wdata_r      <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            if ((state_r == ST_IDLE) && (state_next_s == ST_ACCESS)) begin
                owner_r <= grant_s;
                if (grant_s == OWN_D) begin
                    we_r    <= d_we;
                    addr_r  <= d_addr;
                    wdata_r <= d_wdata;
                end else begin
                    we_r    <= 1'b0;
                    addr_r  <= if_addr;
                    wdata_r <= {DATA_W{1'b0}};
                end
            end else if (state_r == ST_RESP) begin
                last_grant_r <= owner_r;
            end else begin
                owner_r <= owner_r;
            end
        end
    end

    // Next-state logic; mem_ready is only meaningful in ACCESS and beats timeout.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (if_req || d_req) begin
                    state_next_s = ST_ACCESS;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (mem_ready || tmr_expired_s) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_ACCESS;
                end
            end
            ST_RESP: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output decode against the next state, so registered outputs line up with it.
    always_comb begin
        mem_en_n_s = 1'b0;
        mem_we_n_s = 1'b0;
        if_ack_n_s = 1'b0;
        d_ack_n_s  = 1'b0;
        err_n_s    = 1'b0;
        busy_n_s   = (state_next_s != ST_IDLE);
        case (state_next_s)
            ST_ACCESS: begin
                mem_en_n_s = 1'b1;
                if (state_r == ST_IDLE) begin
                    mem_we_n_s = (grant_s == OWN_D) && d_we;
                end else begin
                    mem_we_n_s = we_r;
                end
            end
            ST_RESP: begin
                if (owner_r == OWN_IF) begin
                    if_ack_n_s = 1'b1;
                end else begin
                    d_ack_n_s = 1'b1;
                end
                err_n_s = timeout_s;
            end
            default: begin
                mem_en_n_s = 1'b0;
            end
        endcase
    end

    // Output registers and read-data capture on a successful read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_en_r   <= 1'b0;
            mem_we_r   <= 1'b0;
            if_ack_r   <= 1'b0;
            d_ack_r    <= 1'b0;
            err_r      <= 1'b0;
            busy_r     <= 1'b0;
            if_rdata_r <= {DATA_W{1'b0}};
            d_rdata_r  <= {DATA_W{1'b0}};
        end else begin
            mem_en_r <= mem_en_n_s;
            mem_we_r <= mem_we_n_s;
            if_ack_r <= if_ack_n_s;
            d_ack_r  <= d_ack_n_s;
            err_r    <= err_n_s;
            busy_r   <= busy_n_s;
            if ((state_r == ST_ACCESS) && mem_ready) begin
                if (owner_r == OWN_IF) begin
                    if_rdata_r <= mem_rdata;
                end else if (!we_r) begin
                    d_rdata_r <= mem_rdata;
                end else begin
                    d_rdata_r <= d_rdata_r;
                end
            end else begin
                if_rdata_r <= if_rdata_r;
            end
        end
    end

    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign if_ack    = if_ack_r;
    assign d_ack     = d_ack_r;
    assign err       = err_r;
    assign busy      = busy_r;
    assign if_rdata  = if_rdata_r;
    assign d_rdata   = d_rdata_r;

endmodule
